// File: rtl/bridge_pkg.sv
// Shared constants for mem_io_bridge: IO page, register offsets, register decode
// and the hex-to-seven-segment glyph table.
package bridge_pkg;

    localparam logic [19:0] IoPage    = 20'hFFFFF;
    localparam logic [11:0] OffDigit  = 12'h000;
    localparam logic [11:0] OffTimer  = 12'h020;
    localparam logic [11:0] OffLed    = 12'h060;
    localparam logic [11:0] OffSw     = 12'h070;
    localparam logic [11:0] OffBtn    = 12'h078;

    typedef enum logic [2:0] {
        RegNone,
        RegDigit,
        RegTimer,
        RegLed,
        RegSw,
        RegBtn
    } io_reg_e;

    // Active-low {dp,g,f,e,d,c,b,a}; entry [15] first, entry [0] last.
    localparam logic [15:0][7:0] SegTable = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic io_reg_e io_decode(input logic [11:0] off);
        io_reg_e r;
        case (off)
            OffDigit: r = RegDigit;
            OffTimer: r = RegTimer;
            OffLed:   r = RegLed;
            OffSw:    r = RegSw;
            OffBtn:   r = RegBtn;
            default:  r = RegNone;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner: each digit is lit for SCAN_DIV
// cycles, digit 0 first, with active-low enables and segments.
module seg_scan
    import bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] digits,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      nibble;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        idx_d = idx_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Decode straight from the digit register so a write shows on the next cycle.
    always_comb begin
        nibble  = digits[{idx_q, 2'b00} +: 4];
        dig_en  = ~(8'b1 << idx_q);
        dig_seg = {1'b1, SegTable[nibble][6:0]};
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Core data-memory bridge: routes word accesses to DRAM or the memory-mapped IO page
// (digits, LEDs, switches, buttons). Define BRIDGE_TIMER_EN to add a free-running timer.
module mem_io_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               dram_we,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    logic    io_hit;
    logic    io_we;
    io_reg_e sel;

    logic [31:0] digit_q, digit_d;
    logic [23:0] led_q, led_d;
    logic [23:0] sw_meta_q, sw_sync_q;
    logic [4:0]  btn_meta_q, btn_sync_q;

    always_comb begin
        io_hit     = (cpu_addr[31:12] == IoPage);
        sel        = io_hit ? io_decode(cpu_addr[11:0]) : RegNone;
        io_we      = cpu_we & io_hit;
        dram_we    = cpu_we & ~io_hit;
        dram_addr  = cpu_addr[DRAM_AW+1:2];
        dram_wdata = cpu_wdata;
    end

    always_comb begin
        digit_d = digit_q;
        led_d   = led_q;
        if (io_we && sel == RegDigit) digit_d = cpu_wdata;
        if (io_we && sel == RegLed)   led_d   = cpu_wdata[23:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q    <= '0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            digit_q    <= digit_d;
            led_q      <= led_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // A store takes priority over the free-running increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (io_we && sel == RegTimer) timer_d = cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`endif

    always_comb begin
        cpu_rdata = '0;
        if (!io_hit) begin
            cpu_rdata = dram_rdata;
        end else begin
            case (sel)
                RegDigit: cpu_rdata = digit_q;
                RegLed:   cpu_rdata = {8'b0, led_q};
                RegSw:    cpu_rdata = {8'b0, sw_sync_q};
                RegBtn:   cpu_rdata = {27'b0, btn_sync_q};
`ifdef BRIDGE_TIMER_EN
                RegTimer: cpu_rdata = timer_q;
`endif
                default:  cpu_rdata = '0;
            endcase
        end
    end

    assign led = led_q;

    seg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .digits (digit_q),
        .dig_en (dig_en),
        .dig_seg(dig_seg)
    );

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a small scan divider; expected values are queued
// when stimulus is applied and popped as results are observed.
module tb_mem_io_bridge;

    logic        clk;
    logic        rst_n;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        dram_we;
    logic [13:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  seg_exp[8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    mem_io_bridge #(
        .SCAN_DIV(4),
        .DRAM_AW (14)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .dram_we   (dram_we),
        .dram_addr (dram_addr),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .dig_en    (dig_en),
        .dig_seg   (dig_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: no expected value queued, observed %h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    function automatic logic [7:0] en_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    initial begin
        rst_n      = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        dram_rdata = 32'h0;
        sw         = '0;
        btn        = '0;
        tick(2);

        // Reset state
        push(32'h0);  check("reset_led", led);
        push(32'hFE); check("reset_dig_en", dig_en);
        push(32'hC0); check("reset_dig_seg", dig_seg);
        rst_n = 1'b1;

        // DRAM store
        cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0000_1234;
        push(32'h1); push(32'h4); push(32'h1234);
        #1;
        check("dram_we", dram_we);
        check("dram_addr", dram_addr);
        check("dram_wdata", dram_wdata);
        tick();
        cpu_we = 1'b0;
        push(32'h0); #1; check("led_after_dram_store", led);

        // DRAM load passes through
        cpu_addr = 32'h0000_0100; dram_rdata = 32'hCAFE_F00D;
        push(32'hCAFE_F00D); #1; check("dram_load", cpu_rdata);

        // LED store and readback
        cpu_we = 1'b1; cpu_addr = 32'hFFFF_F060; cpu_wdata = 32'h00AB_CDEF;
        push(32'h0); #1; check("led_store_dram_we", dram_we);
        push(32'hAB_CDEF); push(32'h00AB_CDEF);
        tick();
        cpu_we = 1'b0; #1;
        check("led_value", led);
        check("led_readback", cpu_rdata);

        // Store to switch address is ignored
        cpu_we = 1'b1; cpu_addr = 32'hFFFF_F070; cpu_wdata = 32'hFFFF_FFFF;
        push(32'h0); #1; check("sw_store_dram_we", dram_we);
        tick();
        cpu_we = 1'b0;
        push(32'h0); #1; check("sw_store_ignored", cpu_rdata);

        // Unmapped IO reads zero
        cpu_addr = 32'hFFFF_F100;
        push(32'h0); #1; check("unmapped_read", cpu_rdata);

        // Switch synchronizer: two edges of latency
        cpu_addr = 32'hFFFF_F070; sw = 24'h00F00F;
        push(32'h0); push(32'h0); push(32'h0000_F00F);
        #1; check("sw_sync_0", cpu_rdata);
        tick(); check("sw_sync_1", cpu_rdata);
        tick(); check("sw_sync_2", cpu_rdata);

        // Button synchronizer
        cpu_addr = 32'hFFFF_F078; btn = 5'h15;
        push(32'h0); push(32'h0); push(32'h15);
        #1; check("btn_sync_0", cpu_rdata);
        tick(); check("btn_sync_1", cpu_rdata);
        tick(); check("btn_sync_2", cpu_rdata);

        // Timer address
        cpu_we = 1'b1; cpu_addr = 32'hFFFF_F020; cpu_wdata = 32'hFFFF_FFFE;
        push(32'h0); #1; check("timer_store_dram_we", dram_we);
`ifdef BRIDGE_TIMER_EN
        push(32'hFFFF_FFFE); push(32'hFFFF_FFFF); push(32'h0); push(32'h1);
        tick();
        cpu_we = 1'b0; #1;
        check("timer_0", cpu_rdata);
        tick(); check("timer_1", cpu_rdata);
        tick(); check("timer_2", cpu_rdata);
        tick(); check("timer_3", cpu_rdata);
`else
        push(32'h0);
        tick();
        cpu_we = 1'b0; #1;
        check("timer_absent", cpu_rdata);
`endif

        // Display scan: restart scan, then load digits 7..0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        cpu_we = 1'b1; cpu_addr = 32'hFFFF_F000; cpu_wdata = 32'h7654_3210;
        push(32'h0); #1; check("digit_store_dram_we", dram_we);
        push({24'b0, en_of(0)}); push({24'b0, seg_exp[0]});
        for (int k = 1; k < 8; k++) begin
            repeat (2) begin
                push({24'b0, en_of(k)}); push({24'b0, seg_exp[k]});
            end
        end
        push(32'hFE); push(32'hC0);
        tick();
        cpu_we = 1'b0; #1;
        // Scan counter is already at 1 here because the store edge also ticked it.
        check("scan_en_0", dig_en);
        check("scan_seg_0", dig_seg);
        tick(3);
        for (int k = 1; k < 8; k++) begin
            check($sformatf("scan_en_%0d_first", k), dig_en);
            check($sformatf("scan_seg_%0d_first", k), dig_seg);
            tick(3);
            check($sformatf("scan_en_%0d_last", k), dig_en);
            check($sformatf("scan_seg_%0d_last", k), dig_seg);
            tick();
        end
        check("scan_wrap_en", dig_en);
        check("scan_wrap_seg", dig_seg);

        // Reset mid-scan at digit 5, together with a LED store
        tick(20);
        push(32'hDF); #1; check("scan_at_5", dig_en);
        rst_n = 1'b0; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F060; cpu_wdata = 32'h0012_3456;
        push(32'h0); push(32'hFE); push(32'hC0); push(32'h0);
        tick();
        rst_n = 1'b1; cpu_we = 1'b0; #1;
        check("rst_led", led);
        check("rst_dig_en", dig_en);
        check("rst_dig_seg", dig_seg);
        check("rst_led_readback", cpu_rdata);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
